// File: rtl/ptp_sync_ctrl.sv
// Precise-time sync controller. It keeps the local {ms, sub-ms} timer and issues periodic master sync requests.
// In slave mode it steps or slews the timer from the four PTP timestamps.
module ptp_sync_ctrl #(
  parameter int MS_W        = 31,
  parameter int SUB_W       = 17,
  parameter int CYC_PER_MS  = 125000,
  parameter int SYNC_PERIOD = 125000,
  parameter int STEP_THRESH = 1024,
  parameter int SLEW_DIV    = 16,
  parameter int ERR_MS      = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m_or_s,
  input  logic                  mode_step,
  input  logic                  ts_1_valid,
  input  logic [MS_W+SUB_W-1:0] ts_1,
  input  logic                  ts_2_record,
  input  logic                  ts_3_valid,
  input  logic [MS_W+SUB_W-1:0] ts_3,
  input  logic                  ts_4_valid,
  input  logic [MS_W+SUB_W-1:0] ts_4,
  input  logic                  status_ok,
  output logic [MS_W+SUB_W-1:0] timer,
  output logic                  send_sync_pkt,
  output logic [31:0]           sync_cnt,
  output logic [MS_W+SUB_W-1:0] offset,
  output logic                  offset_neg,
  output logic                  offset_valid,
  output logic                  error1,
  output logic                  slew_busy,
  output logic                  cyc_init
);
  localparam int TW    = MS_W + SUB_W;
  localparam int PER_W = $clog2(SYNC_PERIOD);
  localparam int DIV_W = $clog2(SLEW_DIV);
  localparam logic [SUB_W:0]   CYC_X    = (SUB_W+1)'(CYC_PER_MS);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CYC_PER_MS - 1);
  localparam logic [SUB_W-1:0] SUB_HALF = SUB_W'(CYC_PER_MS / 2);
  localparam logic [SUB_W-1:0] SUB_ONE  = SUB_W'(1);
  localparam logic [SUB_W-1:0] STEP_LIM = SUB_W'(STEP_THRESH);
  localparam logic [MS_W-1:0]  ERR_LIM  = MS_W'(ERR_MS);
  localparam logic [MS_W-1:0]  MS_ONE   = MS_W'(1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(SYNC_PERIOD - 1);
  localparam logic [PER_W-1:0] PER_PRE  = PER_W'(SYNC_PERIOD - 2);
  localparam logic [PER_W-1:0] PER_ONE  = PER_W'(1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SLEW_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  function automatic logic [TW-1:0] ts_add(input logic [TW-1:0] a, input logic [TW-1:0] b);
    logic [SUB_W:0]  s;
    logic [MS_W-1:0] m;
    s = {1'b0, a[SUB_W-1:0]} + {1'b0, b[SUB_W-1:0]};
    m = a[TW-1:SUB_W] + b[TW-1:SUB_W];
    if (s >= CYC_X) begin
      s = s - CYC_X;
      m = m + MS_ONE;
    end
    return {m, s[SUB_W-1:0]};
  endfunction

  function automatic logic [TW-1:0] ts_sub(input logic [TW-1:0] a, input logic [TW-1:0] b);
    logic [SUB_W:0]  s;
    logic [MS_W-1:0] m;
    s = {1'b0, a[SUB_W-1:0]} - {1'b0, b[SUB_W-1:0]};
    m = a[TW-1:SUB_W] - b[TW-1:SUB_W];
    if (a[SUB_W-1:0] < b[SUB_W-1:0]) begin
      s = s + CYC_X;
      m = m - MS_ONE;
    end
    return {m, s[SUB_W-1:0]};
  endfunction

  function automatic logic [TW-1:0] ts_tick(input logic [TW-1:0] t);
    if (t[SUB_W-1:0] == SUB_LAST)
      return {t[TW-1:SUB_W] + MS_ONE, {SUB_W{1'b0}}};
    else
      return {t[TW-1:SUB_W], t[SUB_W-1:0] + SUB_ONE};
  endfunction

  logic [TW-1:0]    timer_reg, t2_reg;
  logic [PER_W-1:0] per_cnt_reg;
  logic             send_reg;
  logic [31:0]      sync_cnt_reg;
  logic             p1_valid_reg, p1_neg_reg;
  logic [TW-1:0]    p1_mag_reg;
  logic [TW-1:0]    offset_reg;
  logic             offset_neg_reg, offset_valid_reg, error1_reg;
  logic             slew_busy_reg, slew_neg_reg;
  logic [SUB_W-1:0] slew_r_reg;
  logic [DIV_W-1:0] slew_div_reg;
  logic [1:0]       cyc_cnt_reg;
  logic             cyc_init_reg;

  // t1, t3, t4 share identical capture logic; index 0/1/2 maps to t1/t3/t4.
  logic [TW-1:0] ext_ts  [3];
  logic          ext_vld [3];
  assign ext_ts[0]  = ts_1;
  assign ext_ts[1]  = ts_3;
  assign ext_ts[2]  = ts_4;
  assign ext_vld[0] = ts_1_valid;
  assign ext_vld[1] = ts_3_valid;
  assign ext_vld[2] = ts_4_valid;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_ts
      logic [TW-1:0] ts_reg;
      always_ff @(posedge clk) begin
        if (reset)             ts_reg <= '0;
        else if (ext_vld[gi])  ts_reg <= ext_ts[gi];
      end
    end
  endgenerate

  logic [TW-1:0]    a_sum, b_sum, d_mag, timer_tick, timer_tick2, step_val;
  logic             d_neg, slave_ok, p2_fire, p3_fire, step_cond, do_step, slew_adj;
  logic [MS_W-1:0]  half_ms;
  logic [SUB_W-1:0] half_sub;

  assign a_sum = ts_add(t2_reg, g_ts[1].ts_reg);
  assign b_sum = ts_add(g_ts[0].ts_reg, g_ts[2].ts_reg);
  assign d_neg = b_sum > a_sum;
  assign d_mag = d_neg ? ts_sub(b_sum, a_sum) : ts_sub(a_sum, b_sum);

  // Halving an odd ms count moves half a millisecond into the sub field.
  assign half_ms  = p1_mag_reg[TW-1:SUB_W] >> 1;
  assign half_sub = (p1_mag_reg[SUB_W-1:0] >> 1) + (p1_mag_reg[SUB_W] ? SUB_HALF : '0);

  assign slave_ok  = status_ok && !m_or_s;
  assign p2_fire   = p1_valid_reg && !slave_ok && !m_or_s;
  assign p3_fire   = offset_valid_reg && !slave_ok && !m_or_s;
  assign step_cond = mode_step || (offset_reg[TW-1:SUB_W] != '0) || (offset_reg[SUB_W-1:0] >= STEP_LIM);
  assign do_step   = p3_fire && step_cond;
  assign slew_adj  = slew_busy_reg && (slew_div_reg == DIV_LAST) && !p3_fire && !m_or_s;

  assign timer_tick  = ts_tick(timer_reg);
  assign timer_tick2 = ts_tick(timer_tick);
  assign step_val    = offset_neg_reg ? ts_add(timer_tick, offset_reg) : ts_sub(timer_tick, offset_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_reg <= '0;
      t2_reg    <= '0;
    end else begin
      if (do_step)       timer_reg <= step_val;
      else if (slew_adj) timer_reg <= slew_neg_reg ? timer_tick2 : timer_reg;
      else               timer_reg <= timer_tick;
      if (ts_2_record)   t2_reg <= timer_reg;
    end
  end

  // Outputs are registered one cycle early so they line up with the terminal count.
  always_ff @(posedge clk) begin
    if (reset) begin
      per_cnt_reg  <= '0;
      send_reg     <= 1'b0;
      sync_cnt_reg <= '0;
      cyc_cnt_reg  <= '0;
      cyc_init_reg <= 1'b0;
    end else begin
      per_cnt_reg <= (per_cnt_reg == PER_LAST) ? '0 : per_cnt_reg + PER_ONE;
      send_reg    <= m_or_s && (per_cnt_reg == PER_PRE);
      if (m_or_s && (per_cnt_reg == PER_PRE))
        sync_cnt_reg <= sync_cnt_reg + 32'd1;
      if (do_step || (per_cnt_reg == PER_PRE)) begin
        cyc_cnt_reg  <= 2'd3;
        cyc_init_reg <= 1'b1;
      end else begin
        cyc_init_reg <= (cyc_cnt_reg != 2'd0);
        if (cyc_cnt_reg != 2'd0) cyc_cnt_reg <= cyc_cnt_reg - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p1_valid_reg     <= 1'b0;
      p1_neg_reg       <= 1'b0;
      p1_mag_reg       <= '0;
      offset_reg       <= '0;
      offset_neg_reg   <= 1'b0;
      offset_valid_reg <= 1'b0;
      error1_reg       <= 1'b0;
    end else begin
      p1_valid_reg <= slave_ok;
      if (slave_ok) begin
        p1_neg_reg <= d_neg;
        p1_mag_reg <= d_mag;
      end
      offset_valid_reg <= p2_fire;
      if (p2_fire) begin
        offset_reg     <= {half_ms, half_sub};
        offset_neg_reg <= p1_neg_reg;
        error1_reg     <= (half_ms >= ERR_LIM);
      end
    end
  end

  // Any P3 result replaces the remaining slew, including a zero offset.
  always_ff @(posedge clk) begin
    if (reset || m_or_s) begin
      slew_busy_reg <= 1'b0;
      slew_neg_reg  <= 1'b0;
      slew_r_reg    <= '0;
      slew_div_reg  <= '0;
    end else if (p3_fire) begin
      slew_div_reg <= '0;
      if (!step_cond && (offset_reg != '0)) begin
        slew_busy_reg <= 1'b1;
        slew_neg_reg  <= offset_neg_reg;
        slew_r_reg    <= offset_reg[SUB_W-1:0];
      end else begin
        slew_busy_reg <= 1'b0;
        slew_r_reg    <= '0;
      end
    end else if (slew_busy_reg) begin
      if (slew_div_reg == DIV_LAST) begin
        slew_div_reg <= '0;
        slew_r_reg   <= slew_r_reg - SUB_ONE;
        if (slew_r_reg == SUB_ONE) slew_busy_reg <= 1'b0;
      end else begin
        slew_div_reg <= slew_div_reg + DIV_ONE;
      end
    end
  end

  assign timer         = timer_reg;
  assign send_sync_pkt = send_reg;
  assign sync_cnt      = sync_cnt_reg;
  assign offset        = offset_reg;
  assign offset_neg    = offset_neg_reg;
  assign offset_valid  = offset_valid_reg;
  assign error1        = error1_reg;
  assign slew_busy     = slew_busy_reg;
  assign cyc_init      = cyc_init_reg;
endmodule

// File: tb/tb_ptp_sync_ctrl.sv
// Directed bench for ptp_sync_ctrl with a 10000-cycle millisecond and a 200-cycle sync period.
// Cycle j is the interval after the j-th clock edge following reset release.
module tb_ptp_sync_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m_or_s = 1'b0, mode_step = 1'b0;
  logic        ts_1_valid = 1'b0, ts_2_record = 1'b0, ts_3_valid = 1'b0, ts_4_valid = 1'b0;
  logic [47:0] ts_1 = '0, ts_3 = '0, ts_4 = '0;
  logic        status_ok = 1'b0;
  logic [47:0] timer, offset;
  logic        send_sync_pkt, offset_neg, offset_valid, error1, slew_busy, cyc_init;
  logic [31:0] sync_cnt;
  int          cyc = 0;
  int          passed = 0, total = 0;

  ptp_sync_ctrl #(
    .MS_W(31), .SUB_W(17), .CYC_PER_MS(10000), .SYNC_PERIOD(200),
    .STEP_THRESH(1024), .SLEW_DIV(16), .ERR_MS(1)
  ) dut (
    .clk(clk), .reset(reset), .m_or_s(m_or_s), .mode_step(mode_step),
    .ts_1_valid(ts_1_valid), .ts_1(ts_1), .ts_2_record(ts_2_record),
    .ts_3_valid(ts_3_valid), .ts_3(ts_3), .ts_4_valid(ts_4_valid), .ts_4(ts_4),
    .status_ok(status_ok), .timer(timer), .send_sync_pkt(send_sync_pkt),
    .sync_cnt(sync_cnt), .offset(offset), .offset_neg(offset_neg),
    .offset_valid(offset_valid), .error1(error1), .slew_busy(slew_busy), .cyc_init(cyc_init)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  function automatic logic [47:0] mk(input int ms, input int sub);
    logic [30:0] m;
    logic [16:0] s;
    m = ms[30:0];
    s = sub[16:0];
    return {m, s};
  endfunction

  task automatic goto(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic do_reset(input logic master);
    @(negedge clk);
    reset = 1'b1; m_or_s = master; mode_step = 1'b0; status_ok = 1'b0; ts_2_record = 1'b0;
    ts_1_valid = 1'b0; ts_3_valid = 1'b0; ts_4_valid = 1'b0;
    ts_1 = '0; ts_3 = '0; ts_4 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic record_t2(input int c);
    goto(c); ts_2_record = 1'b1;
    goto(c + 1); ts_2_record = 1'b0;
  endtask

  task automatic load_ts(input logic [47:0] a, input logic [47:0] b, input logic [47:0] d);
    ts_1 = a; ts_3 = b; ts_4 = d;
    ts_1_valid = 1'b1; ts_3_valid = 1'b1; ts_4_valid = 1'b1;
    @(negedge clk);
    ts_1_valid = 1'b0; ts_3_valid = 1'b0; ts_4_valid = 1'b0;
  endtask

  task automatic pulse_status(input int c);
    goto(c); status_ok = 1'b1;
    goto(c + 1); status_ok = 1'b0;
  endtask

  task automatic test_reset;
    do_reset(1'b0);
    total++; if (timer !== 48'd0) $display("FAIL reset_timer: got %0h want 0", timer); else passed++;
    total++; if (sync_cnt !== 32'd0) $display("FAIL reset_sync_cnt: got %0d want 0", sync_cnt); else passed++;
    total++; if (offset !== 48'd0) $display("FAIL reset_offset: got %0h want 0", offset); else passed++;
    total++; if ({send_sync_pkt, offset_neg, offset_valid, error1, slew_busy, cyc_init} !== 6'b0)
      $display("FAIL reset_flags: got %b want 000000", {send_sync_pkt, offset_neg, offset_valid, error1, slew_busy, cyc_init});
    else passed++;
    $display("test_reset: done");
  endtask

  task automatic test_master;
    do_reset(1'b1);
    goto(198);
    total++; if (send_sync_pkt !== 1'b0) $display("FAIL master_early: got %b want 0", send_sync_pkt); else passed++;
    goto(199);
    total++; if ({send_sync_pkt, cyc_init} !== 2'b11) $display("FAIL master_pulse1: got %b want 11", {send_sync_pkt, cyc_init}); else passed++;
    total++; if (sync_cnt !== 32'd1) $display("FAIL master_cnt1: got %0d want 1", sync_cnt); else passed++;
    goto(200);
    total++; if (send_sync_pkt !== 1'b0) $display("FAIL master_one_cycle: got %b want 0", send_sync_pkt); else passed++;
    total++; if (timer !== mk(0, 200)) $display("FAIL master_timer200: got %0h want %0h", timer, mk(0, 200)); else passed++;
    goto(202);
    total++; if (cyc_init !== 1'b1) $display("FAIL master_cyc_init_hold: got %b want 1", cyc_init); else passed++;
    goto(203);
    total++; if (cyc_init !== 1'b0) $display("FAIL master_cyc_init_end: got %b want 0", cyc_init); else passed++;
    pulse_status(300);
    goto(302);
    total++; if (offset_valid !== 1'b0) $display("FAIL master_ignore_status: got %b want 0", offset_valid); else passed++;
    goto(399);
    total++; if ({send_sync_pkt, sync_cnt} !== {1'b1, 32'd2}) $display("FAIL master_pulse2: got %b/%0d want 1/2", send_sync_pkt, sync_cnt); else passed++;
    goto(10000);
    total++; if (timer !== mk(1, 0)) $display("FAIL master_ms_roll: got %0h want %0h", timer, mk(1, 0)); else passed++;
    total++; if (sync_cnt !== 32'd50) $display("FAIL master_cnt50: got %0d want 50", sync_cnt); else passed++;
    $display("test_master: done");
  endtask

  task automatic test_step;
    do_reset(1'b0);
    record_t2(5000);
    load_ts(mk(0, 0), mk(0, 6000), mk(0, 3000));
    pulse_status(5010);
    total++; if (offset_valid !== 1'b0) $display("FAIL step_valid_early: got %b want 0", offset_valid); else passed++;
    goto(5012);
    total++; if ({offset_valid, offset_neg, error1} !== 3'b100) $display("FAIL step_flags: got %b want 100", {offset_valid, offset_neg, error1}); else passed++;
    total++; if (offset !== mk(0, 4000)) $display("FAIL step_offset: got %0h want %0h", offset, mk(0, 4000)); else passed++;
    goto(5013);
    total++; if (timer !== mk(0, 1013)) $display("FAIL step_timer: got %0h want %0h", timer, mk(0, 1013)); else passed++;
    total++; if ({cyc_init, offset_valid} !== 2'b10) $display("FAIL step_cyc_init_start: got %b want 10", {cyc_init, offset_valid}); else passed++;
    goto(5016);
    total++; if (cyc_init !== 1'b1) $display("FAIL step_cyc_init_hold: got %b want 1", cyc_init); else passed++;
    goto(5017);
    total++; if (cyc_init !== 1'b0) $display("FAIL step_cyc_init_end: got %b want 0", cyc_init); else passed++;
    total++; if (timer !== mk(0, 1017)) $display("FAIL step_timer_after: got %0h want %0h", timer, mk(0, 1017)); else passed++;
    $display("test_step: done");
  endtask

  task automatic test_odd_ms;
    do_reset(1'b0);
    record_t2(50);
    load_ts(mk(0, 0), mk(3, 50), mk(0, 0));
    pulse_status(60);
    goto(62);
    total++; if (offset !== mk(1, 5050)) $display("FAIL odd_offset: got %0h want %0h", offset, mk(1, 5050)); else passed++;
    total++; if ({offset_valid, offset_neg, error1} !== 3'b101) $display("FAIL odd_flags: got %b want 101", {offset_valid, offset_neg, error1}); else passed++;
    goto(63);
    total++; if (timer !== mk('h7FFFFFFE, 5013)) $display("FAIL odd_step_wrap: got %0h want %0h", timer, mk('h7FFFFFFE, 5013)); else passed++;
    $display("test_odd_ms: done");
  endtask

  task automatic test_mode_step;
    do_reset(1'b0);
    mode_step = 1'b1;
    record_t2(100);
    load_ts(mk(0, 0), mk(0, 0), mk(0, 120));
    pulse_status(110);
    goto(112);
    total++; if ({offset, offset_neg, error1} !== {mk(0, 10), 1'b1, 1'b0}) $display("FAIL mstep_offset: got %0h/%b/%b want %0h/1/0", offset, offset_neg, error1, mk(0, 10)); else passed++;
    goto(113);
    total++; if (timer !== mk(0, 123)) $display("FAIL mstep_timer: got %0h want %0h", timer, mk(0, 123)); else passed++;
    total++; if (slew_busy !== 1'b0) $display("FAIL mstep_no_slew: got %b want 0", slew_busy); else passed++;
    mode_step = 1'b0;
    $display("test_mode_step: done");
  endtask

  task automatic test_slew_behind;
    do_reset(1'b0);
    record_t2(9900);
    load_ts(mk(0, 0), mk(0, 0), mk(0, 9920));
    pulse_status(9981);
    goto(9983);
    total++; if ({offset_valid, offset_neg, offset} !== {2'b11, mk(0, 10)}) $display("FAIL slew_offset: got %b%b/%0h want 11/%0h", offset_valid, offset_neg, offset, mk(0, 10)); else passed++;
    goto(9984);
    total++; if ({slew_busy, timer} !== {1'b1, mk(0, 9984)}) $display("FAIL slew_arm: got %b/%0h want 1/%0h", slew_busy, timer, mk(0, 9984)); else passed++;
    goto(9999);
    total++; if (timer !== mk(0, 9999)) $display("FAIL slew_pre_boundary: got %0h want %0h", timer, mk(0, 9999)); else passed++;
    goto(10000);
    total++; if (timer !== mk(1, 1)) $display("FAIL slew_cross_ms: got %0h want %0h", timer, mk(1, 1)); else passed++;
    goto(10143);
    total++; if (slew_busy !== 1'b1) $display("FAIL slew_busy_last: got %b want 1", slew_busy); else passed++;
    goto(10144);
    total++; if (slew_busy !== 1'b0) $display("FAIL slew_busy_end: got %b want 0", slew_busy); else passed++;
    goto(10150);
    total++; if (timer !== mk(1, 160)) $display("FAIL slew_final: got %0h want %0h", timer, mk(1, 160)); else passed++;
    $display("test_slew_behind: done");
  endtask

  task automatic test_slew_abort;
    do_reset(1'b0);
    record_t2(100);
    load_ts(mk(0, 0), mk(0, 0), mk(0, 80));
    pulse_status(110);
    goto(113);
    total++; if (slew_busy !== 1'b1) $display("FAIL abort_armed: got %b want 1", slew_busy); else passed++;
    goto(130);
    total++; if (timer !== mk(0, 129)) $display("FAIL abort_hold: got %0h want %0h", timer, mk(0, 129)); else passed++;
    goto(135);
    ts_4 = mk(0, 100); ts_4_valid = 1'b1;
    goto(136);
    ts_4_valid = 1'b0;
    pulse_status(140);
    goto(142);
    total++; if ({slew_busy, offset_valid, offset} !== {2'b11, 48'd0}) $display("FAIL abort_pre: got %b%b/%0h want 11/0", slew_busy, offset_valid, offset); else passed++;
    goto(143);
    total++; if (slew_busy !== 1'b0) $display("FAIL abort_busy_drop: got %b want 0", slew_busy); else passed++;
    goto(150);
    total++; if (timer !== mk(0, 149)) $display("FAIL abort_discard_r: got %0h want %0h", timer, mk(0, 149)); else passed++;
    $display("test_slew_abort: done");
  endtask

  task automatic test_back_to_back;
    do_reset(1'b0);
    record_t2(100);
    load_ts(mk(0, 0), mk(0, 0), mk(0, 80));
    goto(110);
    status_ok = 1'b1; ts_4 = mk(0, 60); ts_4_valid = 1'b1;
    goto(111);
    ts_4_valid = 1'b0;
    goto(112);
    status_ok = 1'b0;
    total++; if (offset_valid !== 1'b0) $display("FAIL b2b_first_discarded: got %b want 0", offset_valid); else passed++;
    goto(113);
    total++; if ({offset_valid, offset} !== {1'b1, mk(0, 20)}) $display("FAIL b2b_second: got %b/%0h want 1/%0h", offset_valid, offset, mk(0, 20)); else passed++;
    goto(114);
    total++; if (slew_busy !== 1'b1) $display("FAIL b2b_slew: got %b want 1", slew_busy); else passed++;
    $display("test_back_to_back: done");
  endtask

  task automatic test_reset_mid_slew;
    do_reset(1'b0);
    record_t2(100);
    load_ts(mk(0, 0), mk(0, 0), mk(0, 80));
    pulse_status(110);
    goto(120);
    total++; if (slew_busy !== 1'b1) $display("FAIL rst_slew_armed: got %b want 1", slew_busy); else passed++;
    reset = 1'b1;
    @(negedge clk);
    total++; if ({timer, offset} !== 96'd0) $display("FAIL rst_mid_values: got %0h/%0h want 0/0", timer, offset); else passed++;
    total++; if ({slew_busy, cyc_init, offset_valid, offset_neg} !== 4'b0) $display("FAIL rst_mid_flags: got %b want 0000", {slew_busy, cyc_init, offset_valid, offset_neg}); else passed++;
    reset = 1'b0;
    goto(5);
    total++; if ({timer, slew_busy} !== {mk(0, 5), 1'b0}) $display("FAIL rst_restart: got %0h/%b want %0h/0", timer, slew_busy, mk(0, 5)); else passed++;
    $display("test_reset_mid_slew: done");
  endtask

  initial begin
    test_reset();
    test_master();
    test_step();
    test_odd_ms();
    test_mode_step();
    test_slew_behind();
    test_slew_abort();
    test_back_to_back();
    test_reset_mid_slew();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded its cycle budget");
    $fatal(1, "timeout");
  end
endmodule
